// File: rtl/fi_mem_pkg.sv
// rtl/fi_mem_pkg.sv - shared types, LFSR taps and address check for fi_mem_responder
package fi_mem_pkg;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } resp_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic addr_legal(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size_bytes
    );
        return (addr[1:0] == 2'b00) && (addr >= base) && ((addr - base) < size_bytes);
    endfunction

endpackage

// File: rtl/fi_mem_resp_queue.sv
// rtl/fi_mem_resp_queue.sv - in-order response queue, DEPTH 1..4 entries
module fi_mem_resp_queue
    import fi_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  resp_t      push_data,
    input  logic       pop,
    output resp_t      head,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    resp_t      slots [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       do_push;
    logic       do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign full    = (count == 3'(DEPTH));
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    // Slots are cleared on reset so the response outputs read as zero afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fi_mem_responder.sv
// rtl/fi_mem_responder.sv - req/gnt + recv/ack memory target; FI_MEM_RESP_STALL_EN adds LFSR grant stalls
module fi_mem_responder
    import fi_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic [2:0]  outstanding
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SIZE_BYTES = 32'(4 * DEPTH_WORDS);

    if ((DEPTH_WORDS < 1) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
        (MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 4) ||
        (LFSR_SEED == 16'h0000) || ((BASE_ADDR % SIZE_BYTES) != 0)) begin : g_bad_params
        $error("fi_mem_responder: illegal parameter set");
    end

    logic [31:0]      mem_array [DEPTH_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             legal;
    logic             full;
    logic             empty;
    logic             stall;
    logic             accept;
    resp_t            push_data;
    resp_t            head;

`ifdef FI_MEM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign legal    = addr_legal(mem_addr, BASE_ADDR, SIZE_BYTES);
    assign word_idx = IDX_W'((mem_addr - BASE_ADDR) >> 2);

    // Full blocks grant even when the head pops this cycle, keeping gnt off the ack path
    assign mem_gnt = mem_req && !full && !stall && !reset;
    assign accept  = mem_req && mem_gnt;

    always_comb begin
        push_data       = '0;
        push_data.error = !legal;
        if (legal && !mem_wen) begin
            push_data.rdata = mem_array[word_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (accept && legal && mem_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_strb[i]) begin
                    mem_array[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    fi_mem_resp_queue #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (accept),
        .push_data(push_data),
        .pop      (mem_recv && mem_ack),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (outstanding)
    );

    assign mem_recv  = !empty;
    assign mem_rdata = head.rdata;
    assign mem_error = head.error;

endmodule

// File: tb/tb_fi_mem_responder.sv
// tb/tb_fi_mem_responder.sv - scoreboard bench for fi_mem_responder
module tb_fi_mem_responder;
    import fi_mem_pkg::*;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        mem_req   = 1'b0;
    logic        mem_wen   = 1'b0;
    logic [3:0]  mem_strb  = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr  = 32'h0;
    logic        mem_ack   = 1'b0;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding;

    int    total = 0;
    int    bad   = 0;
    resp_t exp_q[$];
    resp_t mon_e;

    always #5 clock = ~clock;

    fi_mem_responder #(
        .DEPTH_WORDS    (1024),
        .BASE_ADDR      (32'h0000_0000),
        .MAX_OUTSTANDING(2),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .outstanding(outstanding)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && mem_recv && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(mem_recv), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_error", 32'(mem_error), 32'(mon_e.error));
                check("resp_rdata", mem_rdata, mon_e.rdata);
            end
        end
    end

`ifdef FI_MEM_RESP_STALL_EN
    logic [15:0] lfsr_m;
    bit          stall_chk = 1'b0;

    always @(posedge clock) begin
        lfsr_m <= reset ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    always @(negedge clock) begin
        if (stall_chk && mem_req && (outstanding < 3'd2)) begin
            check("stall_gnt", 32'(mem_gnt), 32'(!lfsr_m[0]));
        end
    end
`endif

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                         input logic [31:0] addr, input logic exp_err, input logic [31:0] exp_rdata);
        int n;
        n         = 0;
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_strb  = strb;
        mem_wdata = wdata;
        mem_addr  = addr;
        @(negedge clock);
        while (!mem_gnt && n < 40) begin
            n++;
            @(negedge clock);
        end
        if (!mem_gnt) begin
            check("gnt_timeout", 32'(mem_gnt), 32'd1);
        end else begin
            exp_q.push_back(resp_t'{error: exp_err, rdata: exp_rdata});
        end
        tick();
        mem_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n       = 0;
        mem_ack = 1'b1;
        while (outstanding != 3'd0 && n < 50) begin
            n++;
            tick();
        end
        check("drain", 32'(outstanding), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset values, with a request held to show grant is forced low
        mem_req = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("rst_gnt", 32'(mem_gnt), 32'd0);
        check("rst_recv", 32'(mem_recv), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_error", 32'(mem_error), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        tick();
        mem_req = 1'b0;
        reset   = 1'b0;
        tick();

        // Write then read with immediate ack, one-cycle latency
        mem_ack = 1'b1;
        issue(1'b1, 4'hF, 32'hDEADBEEF, 32'h10, 1'b0, 32'h0);
        @(negedge clock);
        check("latency_wr", 32'(mem_recv), 32'd1);
        tick();
        issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF);
        @(negedge clock);
        check("latency_rd", 32'(mem_recv), 32'd1);
        tick();

`ifdef FI_MEM_RESP_STALL_EN
        stall_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 4'hF, 32'h100 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 32'h0);
            issue(1'b0, 4'h0, 32'h0, 32'h40 + 32'(4 * i), 1'b0, 32'h100 + 32'(i));
        end
        stall_chk = 1'b0;
`endif

        // Byte lanes and empty strobe
        issue(1'b1, 4'hF, 32'hFFFFFFFF, 32'h20, 1'b0, 32'h0);
        issue(1'b1, 4'b0101, 32'h11223344, 32'h20, 1'b0, 32'h0);
        issue(1'b1, 4'h0, 32'h00000000, 32'h20, 1'b0, 32'h0);
        issue(1'b0, 4'h0, 32'h0, 32'h20, 1'b0, 32'hFF22FF44);

        // Illegal accesses and upper boundary
        issue(1'b1, 4'hF, 32'h01020304, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 4'h0, 32'h0, 32'h2, 1'b1, 32'h0);
        issue(1'b0, 4'h0, 32'h0, 32'h1000, 1'b1, 32'h0);
        issue(1'b1, 4'hF, 32'hBADBAD00, 32'h1000, 1'b1, 32'h0);
        issue(1'b1, 4'hF, 32'hBADBAD11, 32'h12, 1'b1, 32'h0);
        issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h01020304);
        issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF);
        issue(1'b1, 4'hF, 32'hCAFEF00D, 32'hFFC, 1'b0, 32'h0);
        issue(1'b0, 4'h0, 32'h0, 32'hFFC, 1'b0, 32'hCAFEF00D);
        drain();

        // Backpressure: queue full blocks grant, even in the pop cycle
        mem_ack = 1'b0;
        issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h0, 32'h20, 1'b0, 32'hFF22FF44);
        mem_req  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = 32'h0;
        @(negedge clock);
        check("full_gnt", 32'(mem_gnt), 32'd0);
        check("full_outstanding", 32'(outstanding), 32'd2);
        check("hold_rdata", mem_rdata, 32'hDEADBEEF);
        tick();
        check("hold_rdata_2", mem_rdata, 32'hDEADBEEF);
        mem_ack = 1'b1;
        @(negedge clock);
        check("full_pop_gnt", 32'(mem_gnt), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("after_pop_outstanding", 32'(outstanding), 32'd1);
        issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h01020304);
        drain();

        // Reset with two responses queued
        mem_ack = 1'b0;
        issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h0, 32'h20, 1'b0, 32'hFF22FF44);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("midrst_recv", 32'(mem_recv), 32'd0);
        check("midrst_outstanding", 32'(outstanding), 32'd0);
        tick();
        mem_ack = 1'b1;
        issue(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
